reg_write_arbiter: RTL
======================

Name: reg_write_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit storage register (a bank of D flip-flops) between N_REQ requesters.
- Each requester raises req with its data on its wdata slice.
- The arbiter grants one requester at a time, commits that requester's data into the register, and acknowledges with a one-cycle pulse.
- Sits between independent producer blocks and the shared state register they all update.

Parameters:
N_REQ, 4, number of requesters; legal values 2, 4, 8
WIDTH, 8, width of stored register and of each wdata slice
(derived) ID_W = log2(N_REQ), width of owner field

Ports:
clk  input  1  system clock; all state changes on rising edge
REST  input  1  asynchronous, active-low reset (0 = reset asserted)
req  input  N_REQ  per-requester write request; bit i = requester i
wdata  input  N_REQ*WIDTH  write data; requester i uses bits [i*WIDTH +: WIDTH]
gnt  output  N_REQ  one-hot grant, registered
ack  output  N_REQ  one-hot one-cycle write-done pulse, registered
Q  output  WIDTH  shared register contents
owner  output  ID_W  index of requester that performed the last committed write
busy  output  1  high whenever FSM not in IDLE

Behaviour:
- Reset (REST=0, async, takes effect immediately without waiting for clk):
  - state=IDLE, Q=0, gnt=0, ack=0, owner=0, busy=0.
  - Round-robin pointer ptr=0, so requester 0 has highest priority first.
- FSM states IDLE, GRANT, ACK. Transitions occur on rising clk only.
- IDLE:
  - If req==0, stay; all outputs hold.
  - Otherwise select the winner: first set bit of req searching ptr, ptr+1, …, wrapping modulo N_REQ.
  - Load gnt=onehot(winner) and go to GRANT; busy=1.
- GRANT (exactly one cycle):
  - If req[winner]=1 at the edge: Q<=wdata slice of winner, owner<=winner, ack<=onehot(winner), gnt<=0, ptr<=(winner+1) mod N_REQ; go to ACK.
  - If req[winner]=0 at the edge (abort): no write, Q/owner/ptr unchanged, ack stays 0, gnt<=0; go to IDLE.
  - Data is sampled only at this edge; wdata changes in any other cycle have no effect.
- ACK (exactly one cycle):
  - At the edge: ack<=0; go to IDLE.
  - req is ignored in this state, so a registered requester that drops req on seeing ack is not re-granted.
- Latency and throughput:
  - req sampled at edge E; gnt high after E; Q updated and ack high after E+1; ack low and FSM in IDLE after E+2.
  - Earliest next grant is at E+3, i.e. one write per 3 cycles with continuous requests.
- Output invariants:
  - gnt is zero or one-hot; high only in GRANT.
  - ack is zero or one-hot; high only in ACK.
  - busy = (state != IDLE).
- Requests from non-winners during GRANT/ACK are held off and never lost, as long as they stay asserted.
- Simultaneous events:
  - Multiple requesters in IDLE: round-robin selection only; no other priority.
  - Reset assertion in any state: transaction aborted, Q cleared, no ack emitted.
  - Reset deassertion: FSM starts in IDLE at the next edge.
- Pointer wrap: after winner N_REQ-1, ptr=0.

Test Plan:
1. Reset:
   - REST=0 with req=4'b1111.
   - Required: Q=8'h00, gnt=0, ack=0, owner=0, busy=0 immediately and while held, regardless of clk.
2. Single write:
   - After reset, req=4'b0010, wdata[15:8]=8'hA5.
   - Required: gnt=0010 after edge 1; Q=8'hA5, owner=1, ack=0010 after edge 2; ack=0, busy=0 after edge 3.
3. Continuous contention:
   - req=4'b1111 held; slice i data = 8'h10+i.
   - Required: ack order 0,1,2,3,0 at 3-cycle spacing; Q sequence 10, 11, 12, 13, 10.
4. Abort:
   - req=4'b0100 with wdata[23:16]=8'h3C; drop req[2] during GRANT.
   - Required: no ack, Q and owner unchanged, FSM back in IDLE.
   - Then req=4'b0101: requester 0 wins (ptr unchanged from 0).
5. Wrap-around:
   - Complete a write by requester 3; then req=4'b1001.
   - Required: requester 0 granted next, then requester 3.
6. Async reset mid-transaction:
   - Pull REST low midway through the GRANT cycle.
   - Required: gnt=0 and Q=0 before the next clk edge; no ack afterward; after release, req=4'b0001 completes normally in 3 cycles.

Source files
------------

// File: rtl/reg_write_arbiter_if.sv
// Bus between the producer blocks and the shared-register write arbiter.
// The arbiter takes the slave side; producers (or a bench) drive the master side.
interface reg_write_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] wdata;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       ack;
    logic [WIDTH-1:0]       Q;
    logic [ID_W-1:0]        owner;
    logic                   busy;

    modport master (
        output req, wdata,
        input  gnt, ack, Q, owner, busy
    );

    modport slave (
        input  req, wdata,
        output gnt, ack, Q, owner, busy
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter committing one requester's data at a time into a shared register.
// Each write takes IDLE -> GRANT -> ACK, so continuous traffic yields one write per 3 cycles.
module reg_write_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 REST,
    reg_write_arbiter_if.slave   bus
);
    localparam int ID_W = $clog2(N_REQ);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] ACK   = 2'd2;

    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    logic [1:0]       state;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  win;
    logic [ID_W-1:0]  pick;
    logic [ID_W-1:0]  cand;
    logic             found;
    logic [N_REQ-1:0] gnt_r;
    logic [N_REQ-1:0] ack_r;
    logic [WIDTH-1:0] q_r;
    logic [ID_W-1:0]  owner_r;

    // Search starts at ptr; ID_W-bit addition wraps modulo N_REQ since N_REQ is a power of two.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ptr + ID_W'(k);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge REST) begin
        if (!REST) begin
            state   <= IDLE;
            ptr     <= '0;
            win     <= '0;
            gnt_r   <= '0;
            ack_r   <= '0;
            q_r     <= '0;
            owner_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        win   <= pick;
                        gnt_r <= ONE << pick;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    gnt_r <= '0;
                    // A winner that withdrew its request aborts without touching Q, owner or ptr.
                    if (bus.req[win]) begin
                        q_r     <= bus.wdata[int'(win)*WIDTH +: WIDTH];
                        owner_r <= win;
                        ack_r   <= ONE << win;
                        ptr     <= win + ID_W'(1);
                        state   <= ACK;
                    end else begin
                        state   <= IDLE;
                    end
                end
                ACK: begin
                    ack_r <= '0;
                    state <= IDLE;
                end
                default: begin
                    gnt_r <= '0;
                    ack_r <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt   = gnt_r;
    assign bus.ack   = ack_r;
    assign bus.Q     = q_r;
    assign bus.owner = owner_r;
    assign bus.busy  = (state != IDLE);

endmodule
